// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: control, payload and debug-counter bundle of one pipeline stage register.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             clr_cnt;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output stall, flush, valid, data, clr_cnt,
        input  q_valid, q_data, stall_cnt, bubble_cnt
    );

    modport slave (
        input  stall, flush, valid, data, clr_cnt,
        output q_valid, q_data, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage valid/payload register with stall, flush, squash and saturating debug counters.
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_reg_if.slave  bus
);
    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] pay;
    logic [DEPTH:0]              vld_chain;
    logic [DEPTH:0][WIDTH-1:0]   pay_chain;
    logic                        stall_ev;
    logic                        bubble_ev;

    // Stage 0 takes the squashed input; every later stage takes its predecessor.
    assign vld_chain = {vld, bus.valid};
    assign pay_chain = {pay, bus.valid ? bus.data : RST_VAL};

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            vld <= '0;
            pay <= {DEPTH{RST_VAL}};
        end else if (!bus.stall) begin
            vld <= vld_chain[DEPTH-1:0];
            pay <= pay_chain[DEPTH-1:0];
        end
    end

    assign stall_ev  = bus.stall && !bus.flush;
    assign bubble_ev = bus.flush || (!bus.stall && !bus.valid);

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            bus.stall_cnt  <= '0;
            bus.bubble_cnt <= '0;
        end else begin
            if (stall_ev && bus.stall_cnt != '1)
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            if (bubble_ev && bus.bubble_cnt != '1)
                bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
        end
    end

    assign bus.q_valid = vld[DEPTH-1];
    assign bus.q_data  = pay[DEPTH-1];
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of three pipe_stage_reg configurations (D1/C16, D3/C16, D1/C4).
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(16)) a_if ();
    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(16)) b_if ();
    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(4))  c_if ();

    pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .RST_VAL('0), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .RST_VAL('0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
    pipe_stage_reg #(.WIDTH(32), .DEPTH(1), .RST_VAL('0), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .bus(c_if));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_if.stall = 0; a_if.flush = 0; a_if.valid = 0; a_if.data = '0; a_if.clr_cnt = 0;
        b_if.stall = 0; b_if.flush = 0; b_if.valid = 0; b_if.data = '0; b_if.clr_cnt = 0;
        c_if.stall = 0; c_if.flush = 0; c_if.valid = 0; c_if.data = '0; c_if.clr_cnt = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        a_if.valid = 1; a_if.data = 32'h1234_5678; a_if.stall = 1;
        b_if.valid = 1; b_if.data = 32'h8765_4321; b_if.flush = 1;
        rst = 1;
        tick();
        rst = 0;
        checks++; if (a_if.q_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_if.q_valid); end
        checks++; if (a_if.q_data !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h expected 00000000", a_if.q_data); end
        checks++; if (a_if.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_a_stall_cnt: got %0d expected 0", a_if.stall_cnt); end
        checks++; if (b_if.q_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", b_if.q_valid); end
        checks++; if (b_if.bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_b_bubble_cnt: got %0d expected 0", b_if.bubble_cnt); end
        checks++; if (c_if.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_c_stall_cnt: got %0d expected 0", c_if.stall_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        a_if.valid = 1; a_if.data = 32'hDEAD_BEEF;
        tick();
        checks++; if (a_if.q_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", a_if.q_valid); end
        checks++; if (a_if.q_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", a_if.q_data); end
        checks++; if (a_if.bubble_cnt !== 16'd0) begin errors++; $display("FAIL single_bubble_cnt: got %0d expected 0", a_if.bubble_cnt); end
        a_if.data = 32'h0BAD_F00D;
        tick();
        checks++; if (a_if.q_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL single_next_data: got %h expected 0badf00d", a_if.q_data); end
    endtask

    task automatic test_depth3();
        logic [31:0] exp_d [6] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        logic        exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] in_d  [6] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b_if.valid = (i < 3);
            b_if.data  = in_d[i];
            tick();
            checks++; if (b_if.q_valid !== exp_v[i]) begin errors++; $display("FAIL depth3_valid[%0d]: got %b expected %b", i, b_if.q_valid, exp_v[i]); end
            checks++; if (b_if.q_data !== exp_d[i]) begin errors++; $display("FAIL depth3_data[%0d]: got %h expected %h", i, b_if.q_data, exp_d[i]); end
        end
        checks++; if (b_if.bubble_cnt !== 16'd3) begin errors++; $display("FAIL depth3_bubble_cnt: got %0d expected 3", b_if.bubble_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        b_if.valid = 1;
        b_if.data = 32'hA1; tick();
        b_if.data = 32'hA2; tick();
        b_if.data = 32'hA3; tick();
        b_if.stall = 1; b_if.data = 32'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (b_if.q_valid !== 1'b1 || b_if.q_data !== 32'hA1) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h expected 1/000000a1", i, b_if.q_valid, b_if.q_data); end
        end
        checks++; if (b_if.stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", b_if.stall_cnt); end
        b_if.stall = 0; b_if.valid = 0; b_if.data = '0;
        tick();
        checks++; if (b_if.q_data !== 32'hA2) begin errors++; $display("FAIL stall_resume_a2: got %h expected 000000a2", b_if.q_data); end
        tick();
        checks++; if (b_if.q_data !== 32'hA3) begin errors++; $display("FAIL stall_resume_a3: got %h expected 000000a3", b_if.q_data); end
        tick();
        checks++; if (b_if.q_valid !== 1'b0 || b_if.q_data !== 32'h0) begin errors++; $display("FAIL stall_no_capture: got %b/%h expected 0/00000000", b_if.q_valid, b_if.q_data); end
        checks++; if (b_if.stall_cnt !== 16'd4 || b_if.bubble_cnt !== 16'd3) begin errors++; $display("FAIL stall_counters: got %0d/%0d expected 4/3", b_if.stall_cnt, b_if.bubble_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        b_if.valid = 1;
        b_if.data = 32'hB1; tick();
        b_if.data = 32'hB2; tick();
        b_if.data = 32'hB3; b_if.stall = 1; b_if.flush = 1;
        tick();
        checks++; if (b_if.q_valid !== 1'b0 || b_if.q_data !== 32'h0) begin errors++; $display("FAIL flush_out: got %b/%h expected 0/00000000", b_if.q_valid, b_if.q_data); end
        checks++; if (b_if.bubble_cnt !== 16'd1) begin errors++; $display("FAIL flush_bubble_cnt: got %0d expected 1", b_if.bubble_cnt); end
        checks++; if (b_if.stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_stall_cnt: got %0d expected 0", b_if.stall_cnt); end
        b_if.stall = 0; b_if.flush = 0; b_if.valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b_if.q_valid !== 1'b0) begin errors++; $display("FAIL flush_drain[%0d]: got %b expected 0", i, b_if.q_valid); end
        end
        checks++; if (b_if.bubble_cnt !== 16'd4) begin errors++; $display("FAIL flush_bubble_total: got %0d expected 4", b_if.bubble_cnt); end
    endtask

    task automatic test_squash();
        do_reset();
        a_if.valid = 0; a_if.data = 32'hFFFF_FFFF;
        tick();
        checks++; if (a_if.q_valid !== 1'b0 || a_if.q_data !== 32'h0) begin errors++; $display("FAIL squash_out: got %b/%h expected 0/00000000", a_if.q_valid, a_if.q_data); end
        checks++; if (a_if.bubble_cnt !== 16'd1) begin errors++; $display("FAIL squash_bubble_cnt: got %0d expected 1", a_if.bubble_cnt); end
        a_if.valid = 1; a_if.data = 32'h5;
        tick();
        checks++; if (a_if.q_valid !== 1'b1 || a_if.q_data !== 32'h5 || a_if.bubble_cnt !== 16'd1) begin errors++; $display("FAIL squash_recover: got %b/%h/%0d expected 1/00000005/1", a_if.q_valid, a_if.q_data, a_if.bubble_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        c_if.valid = 1; c_if.data = 32'hC5;
        tick();
        c_if.stall = 1; c_if.data = 32'h77;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (c_if.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_stall_14: got %0d expected 14", c_if.stall_cnt); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (c_if.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_stick: got %0d expected 15", c_if.stall_cnt); end
        checks++; if (c_if.q_valid !== 1'b1 || c_if.q_data !== 32'hC5) begin errors++; $display("FAIL sat_hold: got %b/%h expected 1/000000c5", c_if.q_valid, c_if.q_data); end
        c_if.clr_cnt = 1;
        tick();
        checks++; if (c_if.stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr: got %0d expected 0", c_if.stall_cnt); end
        checks++; if (c_if.q_valid !== 1'b1 || c_if.q_data !== 32'hC5) begin errors++; $display("FAIL sat_clr_pipe: got %b/%h expected 1/000000c5", c_if.q_valid, c_if.q_data); end
        c_if.clr_cnt = 0;
        tick();
        checks++; if (c_if.stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_after_clr: got %0d expected 1", c_if.stall_cnt); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (c_if.q_valid !== 1'b0 || c_if.q_data !== 32'h0 || c_if.stall_cnt !== 4'd0 || c_if.bubble_cnt !== 4'd0) begin errors++; $display("FAIL sat_rst_mid_stall: got %b/%h/%0d/%0d expected 0/00000000/0/0", c_if.q_valid, c_if.q_data, c_if.stall_cnt, c_if.bubble_cnt); end
        c_if.stall = 0; c_if.valid = 0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (c_if.bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_bubble_stick: got %0d expected 15", c_if.bubble_cnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_depth3();
        test_stall();
        test_flush();
        test_squash();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
